// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module      : load_store_unit
//  Description : Wishbone B4 pipelined bus master for the CPU memory phase.
//                One load/store per request, byte/short/word/dword widths,
//                load sign/zero extension, alignment check, bus-error and
//                stall/ack timeout capture.
//  Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    i_enable,
    input  logic                    i_we,
    input  logic [ADDR_WIDTH-1:0]   i_addr,
    input  logic [DATA_WIDTH-1:0]   i_value,
    input  logic [1:0]              i_size,
    input  logic                    i_signed,
    output logic                    o_busy,
    output logic                    o_completed,
    output logic [DATA_WIDTH-1:0]   o_value,
    output logic                    o_fault,
    output logic [1:0]              o_fault_cause,
    output logic [ADDR_WIDTH-1:0]   o_wb_addr,
    output logic [DATA_WIDTH-1:0]   o_wb_data,
    output logic [DATA_WIDTH/8-1:0] o_wb_sel,
    output logic                    o_wb_we,
    output logic                    o_wb_cyc,
    output logic                    o_wb_stb,
    input  logic [DATA_WIDTH-1:0]   i_wb_data,
    input  logic                    i_wb_ack,
    input  logic                    i_wb_err,
    input  logic                    i_wb_stall
);

    localparam int NB = DATA_WIDTH / 8;
    localparam int OB = $clog2(NB);
    localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMEOUT_LIMIT = TW'(TIMEOUT_CYCLES);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] DONE = 2'd3;

    localparam logic [1:0] CAUSE_ALIGN   = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;
    localparam logic [1:0] CAUSE_BUSERR  = 2'b11;

    logic [1:0]            state;
    logic                  we_q;
    logic [1:0]            size_q;
    logic                  signed_q;
    logic [OB-1:0]         off_q;
    logic [TW-1:0]         tmo_cnt;
    logic [TW-1:0]         tmo_next;

    logic [OB-1:0]         req_off;
    logic                  misaligned;
    logic [NB-1:0]         load_lanes;
    logic [DATA_WIDTH-1:0] byte_mask;
    logic [DATA_WIDTH-1:0] rd_shift;
    logic                  sign_bit;
    logic [DATA_WIDTH-1:0] load_result;
    logic                  resp_ok;
    logic                  got_err;
    logic                  got_ack;

    // Lane enables covering the access width, before shifting to the offset
    function automatic logic [NB-1:0] size_lanes(input logic [1:0] s);
        case (s)
            2'd0:    return NB'(1);
            2'd1:    return NB'(3);
            2'd2:    return NB'(15);
            default: return '1;
        endcase
    endfunction

    assign req_off  = i_addr[OB-1:0];
    assign tmo_next = tmo_cnt + TW'(1);

    // Request legality: natural alignment, dword only on a 64-bit bus
    always_comb begin
        misaligned = 1'b0;
        case (i_size)
            2'd1:    misaligned = i_addr[0];
            2'd2:    misaligned = (i_addr[1:0] != 2'b00);
            default: misaligned = (i_size == 2'd3) &&
                                  ((DATA_WIDTH == 32) || (i_addr[2:0] != 3'b000));
        endcase
    end

    // Load path: right-justify the addressed lanes, then extend to full width
    always_comb begin
        rd_shift   = i_wb_data >> {off_q, 3'b000};
        load_lanes = size_lanes(size_q);
        byte_mask  = '0;
        for (int i = 0; i < NB; i++) begin
            byte_mask[8*i +: 8] = {8{load_lanes[i]}};
        end
        case (size_q)
            2'd0:    sign_bit = rd_shift[7];
            2'd1:    sign_bit = rd_shift[15];
            2'd2:    sign_bit = rd_shift[31];
            default: sign_bit = rd_shift[DATA_WIDTH-1];
        endcase
        load_result = (rd_shift & byte_mask) |
                      ((signed_q && sign_bit) ? ~byte_mask : '0);
    end

    // Slave responses count only while the single strobe is, or has been, accepted
    always_comb begin
        resp_ok = (state == WAIT) || ((state == REQ) && !i_wb_stall);
        got_err = resp_ok && i_wb_err;
        got_ack = resp_ok && i_wb_ack && !i_wb_err;
    end

    // Request FSM, latched request fields and result registers
    always_ff @(posedge clk) begin
        if (!reset) begin
            state         <= IDLE;
            we_q          <= 1'b0;
            size_q        <= 2'b00;
            signed_q      <= 1'b0;
            off_q         <= '0;
            tmo_cnt       <= '0;
            o_value       <= '0;
            o_fault       <= 1'b0;
            o_fault_cause <= 2'b00;
            o_wb_addr     <= '0;
            o_wb_data     <= '0;
            o_wb_sel      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_enable) begin
                        we_q          <= i_we;
                        size_q        <= i_size;
                        signed_q      <= i_signed;
                        off_q         <= req_off;
                        tmo_cnt       <= '0;
                        o_value       <= '0;
                        o_wb_addr     <= {i_addr[ADDR_WIDTH-1:OB], {OB{1'b0}}};
                        o_wb_data     <= i_value << {req_off, 3'b000};
                        o_wb_sel      <= size_lanes(i_size) << req_off;
                        if (misaligned) begin
                            state         <= DONE;
                            o_fault       <= 1'b1;
                            o_fault_cause <= CAUSE_ALIGN;
                        end else begin
                            state         <= REQ;
                            o_fault       <= 1'b0;
                            o_fault_cause <= 2'b00;
                        end
                    end
                end
                REQ, WAIT: begin
                    if (got_err) begin
                        state         <= DONE;
                        o_fault       <= 1'b1;
                        o_fault_cause <= CAUSE_BUSERR;
                    end else if (got_ack) begin
                        state   <= DONE;
                        o_value <= we_q ? '0 : load_result;
                    end else if ((TIMEOUT_CYCLES != 0) && (tmo_next == TIMEOUT_LIMIT)) begin
                        state         <= DONE;
                        o_fault       <= 1'b1;
                        o_fault_cause <= CAUSE_TIMEOUT;
                    end else begin
                        if (TIMEOUT_CYCLES != 0) begin
                            tmo_cnt <= tmo_next;
                        end
                        if ((state == REQ) && !i_wb_stall) begin
                            state <= WAIT;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign o_busy      = (state != IDLE);
    assign o_completed = (state == DONE);
    assign o_wb_cyc    = (state == REQ) || (state == WAIT);
    assign o_wb_stb    = (state == REQ);
    assign o_wb_we     = o_wb_cyc && we_q;

endmodule
`default_nettype wire
